spi_slave: RTL and testbench

SPI responder (mode 0, CPOL=0/CPHA=0) used as the far end of the SoC's SPI master, for loopback tests and for external-peripheral emulation on `spi_clk`/`spi_mosi`/`spi_miso`/`spi_nss`. The block oversamples all SPI pins in the system `clk` domain. It shifts out bytes supplied through a one-entry valid/ready transmit buffer and returns each completed received frame as a one-cycle strobe. It sits beside the SoC's SPI slave-select decode; one instance serves one `spi_nss` line.

---
 rtl/spi_slave.sv | 174 +++++++++++++++++
 tb/tb_spi_slave.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// SPI mode-0 responder oversampled in the i_clk domain, with a one-entry transmit buffer.
// Define SPI_SLAVE_LSB_FIRST_EN to put bit 0 first on the wire in both directions.
module spi_slave #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_spi_clk,
  input  logic                  i_spi_nss,
  input  logic                  i_spi_mosi,
  output logic                  o_spi_miso,
  output logic                  o_spi_miso_oe,
  input  logic [DATA_WIDTH-1:0] i_tx_data,
  input  logic                  i_tx_valid,
  output logic                  o_tx_ready,
  output logic [DATA_WIDTH-1:0] o_rx_data,
  output logic                  o_rx_valid,
  output logic                  o_tx_underrun,
  output logic                  o_frame_err,
  output logic                  o_busy
);
  localparam int CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [2:0] PIN_RST = 3'b010;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT} state_t;

  logic [2:0]                        w_pin;
  logic [SYNC_STAGES-1:0][2:0]       r_sync;
  logic                              r_sck_d;
  logic                              r_nss_d;
  logic                              w_sck_s;
  logic                              w_nss_s;
  logic                              w_mosi_s;
  logic                              w_sck_rise;
  logic                              w_sck_fall;
  logic                              w_nss_fall;
  logic                              w_nss_rise;

  state_t                            r_state;
  logic [CNT_W-1:0]                  r_bit_cnt;
  logic                              r_reload;
  logic [DATA_WIDTH-1:0]             r_tx_shift;
  logic [DATA_WIDTH-2:0]             r_rx_shift;
  logic [DATA_WIDTH-1:0]             r_tx_buf;
  logic                              r_tx_full;
  logic [DATA_WIDTH-1:0]             r_rx_data;
  logic                              r_rx_valid;
  logic                              r_tx_underrun;
  logic                              r_frame_err;

  logic [DATA_WIDTH-1:0]             w_rx_word;
  logic [DATA_WIDTH-2:0]             w_rx_keep;
  logic [DATA_WIDTH-1:0]             w_tx_next;
  logic                              w_tx_bit;
  logic [DATA_WIDTH-1:0]             w_tx_fill;

  // All three pins share one synchronizer chain; reset state is an idle bus.
  assign w_pin = {i_spi_mosi, i_spi_nss, i_spi_clk};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync  <= {SYNC_STAGES{PIN_RST}};
      r_sck_d <= 1'b0;
      r_nss_d <= 1'b1;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], w_pin};
      r_sck_d <= w_sck_s;
      r_nss_d <= w_nss_s;
    end
  end

  assign w_sck_s    = r_sync[SYNC_STAGES-1][0];
  assign w_nss_s    = r_sync[SYNC_STAGES-1][1];
  assign w_mosi_s   = r_sync[SYNC_STAGES-1][2];
  assign w_sck_rise = w_sck_s & ~r_sck_d;
  assign w_sck_fall = ~w_sck_s & r_sck_d;
  assign w_nss_fall = ~w_nss_s & r_nss_d;
  assign w_nss_rise = w_nss_s & ~r_nss_d;

`ifdef SPI_SLAVE_LSB_FIRST_EN
  assign w_rx_word = {w_mosi_s, r_rx_shift};
  assign w_rx_keep = w_rx_word[DATA_WIDTH-1:1];
  assign w_tx_next = {1'b0, r_tx_shift[DATA_WIDTH-1:1]};
  assign w_tx_bit  = r_tx_shift[0];
`else
  assign w_rx_word = {r_rx_shift, w_mosi_s};
  assign w_rx_keep = w_rx_word[DATA_WIDTH-2:0];
  assign w_tx_next = {r_tx_shift[DATA_WIDTH-2:0], 1'b0};
  assign w_tx_bit  = r_tx_shift[DATA_WIDTH-1];
`endif

  // An empty buffer feeds zeros into the shifter.
  assign w_tx_fill = r_tx_full ? r_tx_buf : '0;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_bit_cnt     <= '0;
      r_reload      <= 1'b0;
      r_tx_shift    <= '0;
      r_rx_shift    <= '0;
      r_tx_buf      <= '0;
      r_tx_full     <= 1'b0;
      r_rx_data     <= '0;
      r_rx_valid    <= 1'b0;
      r_tx_underrun <= 1'b0;
      r_frame_err   <= 1'b0;
    end else begin
      r_rx_valid    <= 1'b0;
      r_tx_underrun <= 1'b0;
      r_frame_err   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_nss_fall) r_state <= ST_LOAD;
        end
        ST_LOAD: begin
          r_tx_shift    <= w_tx_fill;
          r_tx_underrun <= ~r_tx_full;
          r_tx_full     <= 1'b0;
          r_bit_cnt     <= '0;
          r_reload      <= 1'b0;
          r_state       <= w_nss_s ? ST_IDLE : ST_SHIFT;
        end
        ST_SHIFT: begin
          // Abort outranks a simultaneous sample edge.
          if (w_nss_rise) begin
            r_state     <= ST_IDLE;
            r_frame_err <= (r_bit_cnt != '0);
            r_bit_cnt   <= '0;
            r_reload    <= 1'b0;
            r_tx_shift  <= '0;
            r_rx_shift  <= '0;
          end else if (w_sck_rise) begin
            r_rx_shift <= w_rx_keep;
            if (r_bit_cnt == CNT_W'(DATA_WIDTH - 1)) begin
              r_rx_data  <= w_rx_word;
              r_rx_valid <= 1'b1;
              r_bit_cnt  <= '0;
              r_reload   <= 1'b1;
            end else begin
              r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end
          end else if (w_sck_fall) begin
            if (r_reload) begin
              r_tx_shift    <= w_tx_fill;
              r_tx_underrun <= ~r_tx_full;
              r_tx_full     <= 1'b0;
              r_reload      <= 1'b0;
            end else begin
              r_tx_shift <= w_tx_next;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
      // A write needs an empty buffer, so it never collides with a consume of a full one.
      if (i_tx_valid && !r_tx_full) begin
        r_tx_buf  <= i_tx_data;
        r_tx_full <= 1'b1;
      end
    end
  end

  assign o_spi_miso    = ~w_nss_s & w_tx_bit;
  assign o_spi_miso_oe = ~w_nss_s;
  assign o_busy        = ~w_nss_s;
  assign o_tx_ready    = ~r_tx_full;
  assign o_rx_data     = r_rx_data;
  assign o_rx_valid    = r_rx_valid;
  assign o_tx_underrun = r_tx_underrun;
  assign o_frame_err   = r_frame_err;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: bit-banged SPI master with a transaction-level model of
// the transmit buffer, received frames, underruns and aborts.
module tb_spi_slave;
  localparam int W    = 8;
  localparam int SYNC = 2;
  localparam int HALF = 6;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         spi_clk = 1'b0;
  logic         spi_nss = 1'b1;
  logic         spi_mosi = 1'b0;
  logic [W-1:0] tx_data = '0;
  logic         tx_valid = 1'b0;
  logic         spi_miso;
  logic         spi_miso_oe;
  logic         tx_ready;
  logic [W-1:0] rx_data;
  logic         rx_valid;
  logic         tx_underrun;
  logic         frame_err;
  logic         busy;

  spi_slave #(.DATA_WIDTH(W), .SYNC_STAGES(SYNC)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_spi_clk     (spi_clk),
    .i_spi_nss     (spi_nss),
    .i_spi_mosi    (spi_mosi),
    .o_spi_miso    (spi_miso),
    .o_spi_miso_oe (spi_miso_oe),
    .i_tx_data     (tx_data),
    .i_tx_valid    (tx_valid),
    .o_tx_ready    (tx_ready),
    .o_rx_data     (rx_data),
    .o_rx_valid    (rx_valid),
    .o_tx_underrun (tx_underrun),
    .o_frame_err   (frame_err),
    .o_busy        (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Pulse monitor, sampled on the falling clock edge.
  int           mon_underrun = 0;
  int           mon_frame_err = 0;
  logic [W-1:0] mon_rx_q[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid)    mon_rx_q.push_back(rx_data);
      if (tx_underrun) mon_underrun++;
      if (frame_err)   mon_frame_err++;
    end
  end

  // Reference model: a one-deep buffer and the counters the spec implies.
  logic [W-1:0] mdl_buf_q[$];
  logic [W-1:0] mo_list[$];
  logic [W-1:0] wr_list[$];
  int           exp_underrun = 0;
  int           exp_frame_err = 0;
  logic [W-1:0] exp_rx_last = '0;

  function automatic logic [W-1:0] mdl_take();
    if (mdl_buf_q.size() != 0) return mdl_buf_q.pop_front();
    exp_underrun++;
    return '0;
  endfunction

  function automatic int bit_pos(input int i);
`ifdef SPI_SLAVE_LSB_FIRST_EN
    return i;
`else
    return W - 1 - i;
`endif
  endfunction

  function automatic logic [W-1:0] next_wr();
    if (wr_list.size() != 0) return wr_list.pop_front();
    return W'($urandom);
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tx_write(input logic [W-1:0] d);
    int n;
    n = 0;
    @(negedge clk);
    while (!tx_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!tx_ready) begin
      check("tx_ready_wait", 32'(tx_ready), 1);
    end else begin
      tx_data  = d;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      mdl_buf_q.push_back(d);
      $display("write tx=%02h", d);
    end
  endtask

  task automatic spi_bits(input logic [W-1:0] mo, input int nbits, output logic [W-1:0] mi);
    mi = '0;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = mo[bit_pos(i)];
      wait_cyc(HALF);
      mi[bit_pos(i)] = spi_miso;
      spi_clk = 1'b1;
      wait_cyc(HALF);
      spi_clk = 1'b0;
    end
  endtask

  task automatic check_reset_vals(input string where);
    check({where, "_miso"},     32'(spi_miso), 0);
    check({where, "_oe"},       32'(spi_miso_oe), 0);
    check({where, "_rx_valid"}, 32'(rx_valid), 0);
    check({where, "_underrun"}, 32'(tx_underrun), 0);
    check({where, "_frame_err"},32'(frame_err), 0);
    check({where, "_busy"},     32'(busy), 0);
    check({where, "_tx_ready"}, 32'(tx_ready), 1);
    check({where, "_rx_data"},  32'(rx_data), 0);
  endtask

  // One nss assertion: nfr full frames, then an optional partial frame.
  task automatic session(input int nfr, input int part, input int wr_mask);
    logic [W-1:0] cur, mo, mi, exp_part;
    spi_nss = 1'b0;
    cur = mdl_take();
    wait_cyc(SYNC + 2);
    check("busy", 32'(busy), 1);
    check("miso_oe", 32'(spi_miso_oe), 1);
    for (int f = 0; f < nfr; f++) begin
      mo = (mo_list.size() != 0) ? mo_list.pop_front() : W'($urandom);
      if (wr_mask[f] && mdl_buf_q.size() == 0) begin
        fork
          spi_bits(mo, W, mi);
          begin
            wait_cyc(20);
            tx_write(next_wr());
            wait_cyc(2);
            check("tx_ready_full", 32'(tx_ready), (mdl_buf_q.size() == 0) ? 1 : 0);
          end
        join
      end else begin
        spi_bits(mo, W, mi);
      end
      check("master_rx", 32'(mi), 32'(cur));
      check("underrun_in_frame", 32'(mon_underrun), 32'(exp_underrun));
      if (mon_rx_q.size() == 0) check("rx_count", 0, 1);
      else check("rx_data", 32'(mon_rx_q.pop_front()), 32'(mo));
      exp_rx_last = mo;
      $display("frame mosi=%02h miso=%02h expected_miso=%02h", mo, mi, cur);
      cur = mdl_take();
    end
    if (part > 0) begin
      mo = W'($urandom);
      spi_bits(mo, part, mi);
      exp_part = '0;
      for (int i = 0; i < part; i++) exp_part[bit_pos(i)] = cur[bit_pos(i)];
      check("master_partial", 32'(mi), 32'(exp_part));
      exp_frame_err++;
      $display("abort after %0d bits miso=%02h", part, mi);
    end
    wait_cyc(SYNC + 3);
    spi_nss = 1'b1;
    wait_cyc(HALF + 2);
    check("busy_idle", 32'(busy), 0);
    check("underrun_cnt", 32'(mon_underrun), 32'(exp_underrun));
    check("frame_err_cnt", 32'(mon_frame_err), 32'(exp_frame_err));
    check("rx_extra", 32'(mon_rx_q.size()), 0);
    check("rx_hold", 32'(rx_data), 32'(exp_rx_last));
    check("tx_ready_idle", 32'(tx_ready), (mdl_buf_q.size() == 0) ? 1 : 0);
  endtask

  initial begin
    logic [W-1:0] mi;
    int nfr, part, pre;

    wait_cyc(3);
    check_reset_vals("rst");
    rst = 1'b0;
    wait_cyc(SYNC + 3);
    check_reset_vals("post_rst");

    // Single frame
    tx_write(8'hA5);
    mo_list.push_back(8'h3C);
    session(1, 0, 0);

    // Back-to-back with a mid-frame write
    tx_write(8'h12);
    mo_list.push_back(8'hF0);
    mo_list.push_back(8'h0F);
    wr_list.push_back(8'h34);
    session(2, 0, 1);

    // Underrun at nss fall
    session(1, 0, 0);

    // Abort after 5 bits, then a clean frame
    tx_write(8'h66);
    session(0, 5, 0);
    mo_list.push_back(8'h5A);
    session(1, 0, 0);

    // Reset mid-frame with the buffer full
    tx_write(8'h77);
    spi_nss = 1'b0;
    void'(mdl_take());
    wait_cyc(SYNC + 2);
    spi_bits(8'h55, 3, mi);
    tx_write(8'h99);
    wait_cyc(2);
    check("pre_rst_tx_ready", 32'(tx_ready), 0);
    rst = 1'b1;
    spi_nss = 1'b1;
    spi_clk = 1'b0;
    spi_mosi = 1'b0;
    wait_cyc(2);
    check_reset_vals("mid_rst");
    mdl_buf_q.delete();
    exp_rx_last = '0;
    rst = 1'b0;
    wait_cyc(HALF);
    check("rst_tx_ready", 32'(tx_ready), 1);
    tx_write(8'hC3);
    session(1, 0, 0);

`ifdef SPI_SLAVE_LSB_FIRST_EN
    tx_write(8'h01);
    mo_list.push_back(8'h80);
    session(1, 0, 0);
`endif

    // Randomized sessions
    for (int s = 0; s < 24; s++) begin
      nfr  = $urandom_range(0, 3);
      part = ($urandom_range(0, 2) == 0) ? $urandom_range(1, W - 1) : 0;
      pre  = $urandom_range(0, 1);
      if (pre != 0) begin
        if (mdl_buf_q.size() == 0) tx_write(W'($urandom));
        else check("tx_ready_held", 32'(tx_ready), 0);
      end
      session(nfr, part, $urandom_range(0, 7));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
